// File: rtl/permn_pkg.sv
// Shared constants and digit-packing helpers for the factorial-expansion permutation engine.
package permn_pkg;
   localparam int N_MAX = 16;
   localparam int W_MAX = 4;
   localparam int VW    = N_MAX * W_MAX;

   typedef logic [VW-1:0] dvec_t;

   function automatic logic [W_MAX-1:0] dig_get(input dvec_t vec, input int idx, input int w);
      return W_MAX'(vec >> (idx * w)) & W_MAX'((1 << w) - 1);
   endfunction

   function automatic dvec_t dig_put(input dvec_t vec, input int idx, input int w,
                                     input logic [W_MAX-1:0] d);
      dvec_t m;
      m = dvec_t'((1 << w) - 1) << (idx * w);
      return (vec & ~m) | ((dvec_t'(d) << (idx * w)) & m);
   endfunction

   function automatic logic [W_MAX-1:0] sat_dig(input logic [W_MAX-1:0] d,
                                                input logic [W_MAX-1:0] lim);
      return (d > lim) ? lim : d;
   endfunction

   function automatic dvec_t ident(input int n, input int w);
      dvec_t v;
      v = '0;
      for (int k = 0; k < n; k++) v = dig_put(v, k, w, W_MAX'(k));
      return v;
   endfunction
endpackage

// File: rtl/fex2perm_n.sv
// Combinational factorial-expansion to permutation decoder (Lehmer-style list removal).
module fex2perm_n
   import permn_pkg::*;
#(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N*W-1:0] fex,
   output logic [N*W-1:0] perm
);

   always_comb begin
      dvec_t            lst;
      dvec_t            p;
      logic [W_MAX-1:0] f;
      logic [W_MAX-1:0] idx;
      lst = ident(N, W);
      p   = '0;
      f   = '0;
      idx = '0;
      // Highest element first; each pick closes the gap so the list stays dense.
      for (int i = N - 1; i >= 0; i--) begin
         f   = (i == 0) ? W_MAX'(0) : dig_get(dvec_t'(fex), i, W);
         idx = W_MAX'(i) - f;
         p   = dig_put(p, i, W, dig_get(lst, int'(idx), W));
         for (int k = 0; k < N - 1; k++)
            if (k >= int'(idx)) lst = dig_put(lst, k, W, dig_get(lst, k + 1, W));
      end
      perm = p[N*W-1:0];
   end

endmodule

// File: rtl/permn_eng.sv
// Mixed-radix factorial-expansion counter with registered permutation output.
// Define PERMN_ENG_DEC_EN to enable decrement (dir=1); otherwise dir is ignored.
module permn_eng
   import permn_pkg::*;
#(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic           CLK,
   input  logic           RST_N,
   input  logic           load,
   input  logic [N*W-1:0] load_fex,
   input  logic           nxt,
   input  logic           dir,
   output logic [N*W-1:0] fex,
   output logic [N*W-1:0] perm,
   output logic           perm_vld,
   output logic           wrap
);

   localparam dvec_t PERM_ID = ident(N, W);

   logic [N*W-1:0] fex_q, fex_d;
   logic [N*W-1:0] perm_q, perm_d;
   logic           vld_q, vld_d;
   logic           wrap_q, wrap_d;

`ifndef PERMN_ENG_DEC_EN
   logic unused_dir;
   assign unused_dir = dir;
`endif

   always_comb begin
      dvec_t            cur;
      dvec_t            nx;
      logic             cy;
      logic [W_MAX-1:0] d;
      logic [W_MAX-1:0] lim;
      fex_d  = fex_q;
      wrap_d = 1'b0;
      vld_d  = 1'b1;
      cur    = dvec_t'(fex_q);
      nx     = '0;
      cy     = 1'b0;
      d      = '0;
      lim    = '0;
      if (load) begin
         for (int i = 1; i < N; i++) begin
            lim = W_MAX'(i);
            d   = sat_dig(dig_get(dvec_t'(load_fex), i, W), lim);
            nx  = dig_put(nx, i, W, d);
         end
         fex_d = nx[N*W-1:0];
         vld_d = 1'b0;
      end else if (nxt) begin
         nx = cur;
         cy = 1'b1;
         // Ripple carry/borrow from f_1 upward; digit i has radix i+1.
         for (int i = 1; i < N; i++) begin
            lim = W_MAX'(i);
            d   = dig_get(cur, i, W);
`ifdef PERMN_ENG_DEC_EN
            if (dir) begin
               if (cy) begin
                  if (d == '0) d = lim;
                  else begin
                     d  = d - W_MAX'(1);
                     cy = 1'b0;
                  end
               end
            end else
`endif
            begin
               if (cy) begin
                  if (d == lim) d = '0;
                  else begin
                     d  = d + W_MAX'(1);
                     cy = 1'b0;
                  end
               end
            end
            nx = dig_put(nx, i, W, d);
         end
         fex_d  = nx[N*W-1:0];
         wrap_d = cy;
         vld_d  = 1'b0;
      end
   end

   fex2perm_n #(.N(N), .W(W)) u_dec (
      .fex  (fex_q),
      .perm (perm_d)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         fex_q  <= '0;
         perm_q <= PERM_ID[N*W-1:0];
         vld_q  <= 1'b1;
         wrap_q <= 1'b0;
      end else begin
         fex_q  <= fex_d;
         perm_q <= perm_d;
         vld_q  <= vld_d;
         wrap_q <= wrap_d;
      end
   end

   assign fex      = fex_q;
   assign perm     = perm_q;
   assign perm_vld = vld_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_permn_eng.sv
// Directed bench for permn_eng at N=4, W=2; expectations are hand-packed constants.
module tb_permn_eng;

   localparam int N = 4;
   localparam int W = 2;

   logic           CLK;
   logic           RST_N;
   logic           load;
   logic [N*W-1:0] load_fex;
   logic           nxt;
   logic           dir;
   logic [N*W-1:0] fex;
   logic [N*W-1:0] perm;
   logic           perm_vld;
   logic           wrap;

   int n_cmp;
   int n_bad;

   permn_eng #(.N(N)) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .load     (load),
      .load_fex (load_fex),
      .nxt      (nxt),
      .dir      (dir),
      .fex      (fex),
      .perm     (perm),
      .perm_vld (perm_vld),
      .wrap     (wrap)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // fex packing {f3,f2,f1,f0}, perm packing {p3,p2,p1,p0}
   localparam logic [7:0] FX_000  = 8'h00;
   localparam logic [7:0] FX_100  = 8'h04;
   localparam logic [7:0] FX_123  = 8'hE4;
   localparam logic [7:0] FX_333  = 8'hFC;
   localparam logic [7:0] PM_0123 = 8'hE4;
   localparam logic [7:0] PM_1023 = 8'hE1;
   localparam logic [7:0] PM_3210 = 8'h1B;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   bit seen [256];
   int n_wrap;
   int n_dist;

   initial begin
      n_cmp = 0; n_bad = 0;
      RST_N = 1'b1; load = 1'b0; load_fex = '0; nxt = 1'b0; dir = 1'b0;
      #2 RST_N = 1'b0;
      #1;
      chk("rst_fex",  32'(fex), 32'(FX_000));
      chk("rst_perm", 32'(perm), 32'(PM_0123));
      chk("rst_vld",  32'(perm_vld), 32'd1);
      chk("rst_wrap", 32'(wrap), 32'd0);
      tick();
      RST_N = 1'b1;

      // load (1,0,0) with a nonzero digit 0 that must be dropped
      load = 1'b1; load_fex = FX_100 | 8'h03;
      tick();
      load = 1'b0;
      chk("ld_fex",   32'(fex), 32'(FX_100));
      chk("ld_vld0",  32'(perm_vld), 32'd0);
      chk("ld_perm0", 32'(perm), 32'(PM_0123));
      chk("ld_wrap",  32'(wrap), 32'd0);
      tick();
      chk("ld_perm",  32'(perm), 32'(PM_1023));
      chk("ld_vld1",  32'(perm_vld), 32'd1);

      // increment from maximum wraps to zero
      load = 1'b1; load_fex = FX_123;
      tick();
      load = 1'b0;
      chk("max_fex", 32'(fex), 32'(FX_123));
      nxt = 1'b1; dir = 1'b0;
      tick();
      nxt = 1'b0;
      chk("inc_wrap_fex", 32'(fex), 32'(FX_000));
      chk("inc_wrap",     32'(wrap), 32'd1);
      chk("inc_wrap_vld", 32'(perm_vld), 32'd0);
      tick();
      chk("inc_wrap_perm", 32'(perm), 32'(PM_0123));
      chk("inc_wrap_off",  32'(wrap), 32'd0);
      chk("inc_wrap_vld1", 32'(perm_vld), 32'd1);

      // 24 back-to-back steps from zero cover every permutation once
      n_wrap = 0;
      nxt = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         tick();
         seen[perm] = 1'b1;
         if (wrap) n_wrap++;
         chk($sformatf("run_vld_%0d", k),  32'(perm_vld), 32'd0);
         chk($sformatf("run_wrap_%0d", k), 32'(wrap), (k == 24) ? 32'd1 : 32'd0);
      end
      nxt = 1'b0;
      chk("run_last_perm", 32'(perm), 32'(PM_3210));
      chk("run_end_fex",   32'(fex), 32'(FX_000));
      n_dist = 0;
      for (int v = 0; v < 256; v++) if (seen[v]) n_dist++;
      chk("run_distinct", 32'(n_dist), 32'd24);
      chk("run_nwrap",    32'(n_wrap), 32'd1);
      tick();
      chk("run_idle_vld",  32'(perm_vld), 32'd1);
      chk("run_idle_perm", 32'(perm), 32'(PM_0123));

      // dir=1 step from zero
      nxt = 1'b1; dir = 1'b1;
      tick();
      nxt = 1'b0; dir = 1'b0;
`ifdef PERMN_ENG_DEC_EN
      chk("dec_fex",  32'(fex), 32'(FX_123));
      chk("dec_wrap", 32'(wrap), 32'd1);
      tick();
      chk("dec_perm", 32'(perm), 32'(PM_3210));
`else
      chk("dec_fex",  32'(fex), 32'(FX_100));
      chk("dec_wrap", 32'(wrap), 32'd0);
      tick();
      chk("dec_perm", 32'(perm), 32'(PM_1023));
`endif

      // load beats nxt, digits saturate; then async reset mid-operation
      load = 1'b1; nxt = 1'b1; load_fex = FX_333;
      tick();
      load = 1'b0; nxt = 1'b0; load_fex = '0;
      chk("sat_fex",  32'(fex), 32'(FX_123));
      chk("sat_wrap", 32'(wrap), 32'd0);
      chk("sat_vld",  32'(perm_vld), 32'd0);
      #1 RST_N = 1'b0;
      #1;
      chk("arst_fex",  32'(fex), 32'(FX_000));
      chk("arst_perm", 32'(perm), 32'(PM_0123));
      chk("arst_vld",  32'(perm_vld), 32'd1);
      chk("arst_wrap", 32'(wrap), 32'd0);
      #2 RST_N = 1'b1;
      tick();
      chk("post_fex",  32'(fex), 32'(FX_000));
      chk("post_perm", 32'(perm), 32'(PM_0123));
      chk("post_vld",  32'(perm_vld), 32'd1);
      chk("post_wrap", 32'(wrap), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
